code_lock_checker: RTL

- Consumer stage directly downstream of the switch I/O encoder.
- Takes the encoder's packed 4-digit entry (Code, one nibble per digit, unused nibbles 4'hF) and its digit count (Code_Bit).
- On an Enter press, compares the entry against a stored password and drives lock/alarm state with retry limiting and a timed lockout.
- While open, a new password can be written.

---
 rtl/code_lock_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/code_lock_checker.sv
// Code lock checker: compares a 4-digit entry against a stored password,
// with retry limiting, a timed alarm lockout, and password update while open.
// Ports: CLK/RESET (sync, active high); Code, Code_Bit, Enter, Set_Mode,
// and Lock_Req are inputs. Unlock, Alarm, the pulses Err, Short_Err, Pwd_Set
// and Entry_Clr, plus Fail_Cnt and State are outputs.
module code_lock_checker #(
  parameter int          DIGITS      = 4,
  parameter int          MAX_TRIES   = 3,
  parameter int          OPEN_CYCLES = 500,
  parameter int          LOCK_CYCLES = 1000,
  parameter logic [15:0] DEFAULT_PWD = 16'h1234
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] Code,
  input  logic [2:0]  Code_Bit,
  input  logic        Enter,
  input  logic        Set_Mode,
  input  logic        Lock_Req,
  output logic        Unlock,
  output logic        Alarm,
  output logic        Err,
  output logic        Short_Err,
  output logic        Pwd_Set,
  output logic        Entry_Clr,
  output logic [3:0]  Fail_Cnt,
  output logic [2:0]  State
);

  localparam int TMAX =
    (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [4:0]    MAX_T     = 5'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_LOCKED = 3'd0,
    S_CHECK  = 3'd1,
    S_OPEN   = 3'd2,
    S_ALARM  = 3'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    fail, fail_n;
  logic [15:0]   pwd, pwd_n;
  logic [15:0]   entry, entry_n;
  logic          enter_d;
  logic          err_n, short_n, pset_n, clr_n;
  logic          unlock_q, alarm_q;
  logic          err_q, short_q, pset_q, clr_q;

  logic       press;
  logic       full;
  logic [4:0] fail_inc;
  logic [3:0] fail_sat;

  assign press    = Enter & ~enter_d;
  assign full     = (Code_Bit == 3'(DIGITS));
  assign fail_inc = {1'b0, fail} + 5'd1;
  assign fail_sat = (fail_inc > MAX_T) ? MAX_T[3:0] : fail_inc[3:0];

  // State register and all registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_LOCKED;
      timer    <= '0;
      fail     <= '0;
      pwd      <= DEFAULT_PWD;
      entry    <= '0;
      // Held-high Enter across reset must not look like a press
      enter_d  <= 1'b1;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
      short_q  <= 1'b0;
      pset_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      fail     <= fail_n;
      pwd      <= pwd_n;
      entry    <= entry_n;
      enter_d  <= Enter;
      unlock_q <= (state_n == S_OPEN);
      alarm_q  <= (state_n == S_ALARM);
      err_q    <= err_n;
      short_q  <= short_n;
      pset_q   <= pset_n;
      clr_q    <= clr_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    timer_n = timer;
    fail_n  = fail;
    pwd_n   = pwd;
    entry_n = entry;
    err_n   = 1'b0;
    short_n = 1'b0;
    pset_n  = 1'b0;
    clr_n   = 1'b0;
    unique case (state)
      S_LOCKED: begin
        if (press) begin
          if (full) begin
            entry_n = Code;
            state_n = S_CHECK;
          end else begin
            short_n = 1'b1;
          end
        end
      end
      S_CHECK: begin
        clr_n = 1'b1;
        if (entry == pwd) begin
          state_n = S_OPEN;
          fail_n  = '0;
          timer_n = OPEN_LOAD;
        end else begin
          err_n  = 1'b1;
          fail_n = fail_sat;
          if (fail_inc >= MAX_T) begin
            state_n = S_ALARM;
            timer_n = LOCK_LOAD;
          end else begin
            state_n = S_LOCKED;
          end
        end
      end
      S_OPEN: begin
        if (Lock_Req) begin
          state_n = S_LOCKED;
          timer_n = '0;
        end else if (press && Set_Mode) begin
          // Any set attempt counts as activity
          timer_n = OPEN_LOAD;
          if (full) begin
            pwd_n  = Code;
            pset_n = 1'b1;
            clr_n  = 1'b1;
          end else begin
            short_n = 1'b1;
          end
        end else if (timer == '0) begin
          state_n = S_LOCKED;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_ALARM: begin
        if (timer == '0) begin
          state_n = S_LOCKED;
          fail_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = S_LOCKED;
        timer_n = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    State     = state;
    Unlock    = unlock_q;
    Alarm     = alarm_q;
    Err       = err_q;
    Short_Err = short_q;
    Pwd_Set   = pset_q;
    Entry_Clr = clr_q;
    Fail_Cnt  = fail;
  end

endmodule
